fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 117 +++++++++++
 tb/tb_fifo_wr_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin arbiter feeding N requesters into one async-FIFO write port
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DW_W      = 64,
  parameter int MAX_BEATS = 16,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1),
  localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      last,
  input  logic [NREQ*DW_W-1:0] data_i,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  input  logic                 fifo_full,
  output logic                 fifo_w_req,
  output logic [DW_W-1:0]      fifo_data,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic                 busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_owner_q;

  logic            win_vld_d;
  logic [OW-1:0]   win_idx_d;
  logic [OW-1:0]   cand;
  logic            own_req;
  logic            own_last;
  logic            beat_fire;
  logic            cap_hit;
  logic            release_d;

  // Round-robin pick: first asserted req scanning upward from last_owner+1 with wrap
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = OW'((int'(last_owner_q) + 1 + k) % NREQ);
      if (!win_vld_d && req[cand]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand;
      end
    end
  end

  // Beat acceptance is purely combinational so backpressure stalls in the same cycle
  always_comb begin
    ack        = gnt_q & req & {NREQ{~fifo_full}};
    fifo_w_req = |ack;
    own_req    = |(gnt_q & req);
    own_last   = |(gnt_q & last);
    beat_fire  = fifo_w_req;
    cap_hit    = beat_fire && (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
    release_d  = !own_req || (beat_fire && (own_last || cap_hit));
  end

  // Owner data mux; gnt is one-hot or zero so an all-zero grant yields zero data
  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        fifo_data = data_i[i*DW_W +: DW_W];
      end
    end
  end

  // Two-state grant FSM; beat_cnt is kept after release until the next grant clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      beat_cnt_q   <= '0;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            state_q    <= XFER;
            gnt_q      <= NREQ'(1) << win_idx_d;
            owner_q    <= win_idx_d;
            beat_cnt_q <= '0;
          end else begin
            gnt_q <= '0;
          end
        end
        XFER: begin
          if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
          if (release_d) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            last_owner_q <= owner_q;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign beat_cnt = beat_cnt_q;
  assign busy     = (state_q == XFER);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - scoreboard testbench for fifo_wr_arb
module tb_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req, last, gnt, ack;
  logic [3:0]      req_base, drop_mask;
  logic [255:0]    data_i;
  logic            fifo_full, fifo_w_req;
  logic [63:0]     fifo_data;
  logic [2:0]      beat_cnt;
  logic            busy;

  logic [63:0]     pq_data [4][$];
  bit              pq_last [4][$];
  logic [63:0]     exp_q [$];
  logic [3:0]      exp_gnt [$];
  logic [3:0]      prev_gnt, acc;
  int              total, bad;

  assign req = req_base & ~drop_mask;

  fifo_wr_arb #(.NREQ(4), .DW_W(64), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .data_i(data_i),
    .gnt(gnt), .ack(ack), .fifo_full(fifo_full), .fifo_w_req(fifo_w_req),
    .fifo_data(fifo_data), .beat_cnt(beat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(int i, int p, int b);
    return {16'hA5A5, 8'(i), 8'(p), 32'(b)};
  endfunction

  task automatic enq(int i, int p, int n, int l);
    for (int b = 1; b <= n; b++) begin
      pq_data[i].push_back(mk(i, p, b));
      pq_last[i].push_back(b == l);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_base[i] = (pq_data[i].size() != 0);
      data_i[i*DW +: DW] = (pq_data[i].size() != 0) ? pq_data[i][0] : 64'd0;
      last[i] = (pq_last[i].size() != 0) ? pq_last[i][0] : 1'b0;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++)
      if (pq_data[i].size() != 0 && !drop_mask[i]) return 1'b1;
    return 1'b0;
  endfunction

  // one clock: scoreboard at negedge+1, requester model update at posedge+1, return at negedge
  task automatic tick();
    logic [63:0] e;
    logic [3:0]  g;
    #1;
    if (fifo_full) begin
      total++;
      if (fifo_w_req !== 1'b0) begin bad++; $display("FAIL write_while_full: fifo_w_req=%b required 0", fifo_w_req); end
    end
    if (fifo_w_req === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL unexpected_write: data=%h required no write", fifo_data); end
      else begin
        e = exp_q.pop_front();
        if (fifo_data !== e) begin bad++; $display("FAIL fifo_data: got %h required %h", fifo_data, e); end
      end
    end
    if (gnt !== prev_gnt && gnt !== 4'b0) begin
      total++;
      if (prev_gnt !== 4'b0) begin bad++; $display("FAIL regrant_no_idle: prev=%b now=%b required idle gap", prev_gnt, gnt); end
      total++;
      if (exp_gnt.size() == 0) begin bad++; $display("FAIL unexpected_grant: got %b required none", gnt); end
      else begin
        g = exp_gnt.pop_front();
        if (gnt !== g) begin bad++; $display("FAIL grant_order: got %b required %b", gnt, g); end
      end
    end
    prev_gnt = gnt;
    acc = ack;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && pq_data[i].size() != 0) begin
        void'(pq_data[i].pop_front());
        void'(pq_last[i].pop_front());
      end
    end
    drive();
    @(negedge clk);
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while ((pending() || busy || exp_q.size() != 0) && n < budget) begin tick(); n++; end
    total++;
    if (n >= budget) begin bad++; $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    repeat (2) begin
      total++;
      if ({gnt, ack, fifo_w_req, beat_cnt, busy} !== 12'd0 || fifo_data !== 64'd0) begin
        bad++; $display("FAIL reset_outputs: gnt=%b ack=%b wr=%b cnt=%0d busy=%b data=%h required all 0",
                        gnt, ack, fifo_w_req, beat_cnt, busy, fifo_data);
      end
      tick();
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [11];
    seq = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd4, 4'd0, 4'd8, 4'd0, 4'd1, 4'd0};
    enq(0, 0, 1, 1); enq(0, 1, 1, 1); enq(1, 0, 1, 1); enq(2, 0, 1, 1); enq(3, 0, 1, 1);
    exp_q.push_back(mk(0, 0, 1)); exp_q.push_back(mk(1, 0, 1)); exp_q.push_back(mk(2, 0, 1));
    exp_q.push_back(mk(3, 0, 1)); exp_q.push_back(mk(0, 1, 1));
    exp_gnt.push_back(4'd1); exp_gnt.push_back(4'd2); exp_gnt.push_back(4'd4);
    exp_gnt.push_back(4'd8); exp_gnt.push_back(4'd1);
    for (int k = 0; k < 11; k++) begin
      tick();
      total++;
      if (gnt !== seq[k]) begin bad++; $display("FAIL rr_gnt[%0d]: got %b required %b", k, gnt, seq[k]); end
    end
    wait_idle("rr", 20);
  endtask

  task automatic test_basic();
    logic [3:0] gseq [5];
    logic       wseq [5];
    gseq = '{4'd2, 4'd2, 4'd0, 4'd4, 4'd0};
    wseq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    enq(1, 0, 2, 2); enq(2, 0, 1, 1);
    exp_q.push_back(mk(1, 0, 1)); exp_q.push_back(mk(1, 0, 2)); exp_q.push_back(mk(2, 0, 1));
    exp_gnt.push_back(4'd2); exp_gnt.push_back(4'd4);
    tick();
    total++;
    if (req !== 4'b0110 || gnt !== 4'b0) begin bad++; $display("FAIL basic_latency: req=%b gnt=%b required 0110/0000", req, gnt); end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (gnt !== gseq[k] || fifo_w_req !== wseq[k]) begin
        bad++; $display("FAIL basic_step[%0d]: gnt=%b wr=%b required %b/%b", k, gnt, fifo_w_req, gseq[k], wseq[k]);
      end
      if (k == 2) begin
        total++;
        if (beat_cnt !== 3'd2) begin bad++; $display("FAIL basic_cnt_hold: got %0d required 2", beat_cnt); end
      end
    end
    wait_idle("basic", 20);
  endtask

  task automatic test_backpressure();
    int n = 0;
    enq(0, 0, 4, 4);
    for (int b = 1; b <= 4; b++) exp_q.push_back(mk(0, 0, b));
    exp_gnt.push_back(4'd1);
    tick();
    while (beat_cnt !== 3'd2 && n < 20) begin tick(); n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL bp_reach_timeout: cnt=%0d required 2", beat_cnt); end
    fifo_full = 1'b1;
    repeat (3) begin
      #1;
      total++;
      if (ack !== 4'b0 || fifo_w_req !== 1'b0 || gnt !== 4'b0001 || beat_cnt !== 3'd2) begin
        bad++; $display("FAIL bp_freeze: ack=%b wr=%b gnt=%b cnt=%0d required 0/0/0001/2", ack, fifo_w_req, gnt, beat_cnt);
      end
      tick();
    end
    fifo_full = 1'b0;
    wait_idle("bp", 20);
    total++;
    if (beat_cnt !== 3'd4 || gnt !== 4'b0) begin bad++; $display("FAIL bp_final: cnt=%0d gnt=%b required 4/0000", beat_cnt, gnt); end
  endtask

  task automatic test_max_beats();
    int n = 0;
    enq(0, 1, 6, 6);
    for (int b = 1; b <= 4; b++) exp_q.push_back(mk(0, 1, b));
    exp_q.push_back(mk(2, 1, 1)); exp_q.push_back(mk(0, 1, 5)); exp_q.push_back(mk(0, 1, 6));
    exp_gnt.push_back(4'd1); exp_gnt.push_back(4'd4); exp_gnt.push_back(4'd1);
    while (gnt !== 4'b0001 && n < 10) begin tick(); n++; end
    enq(2, 1, 1, 1);
    tick();
    total++;
    if (req[2] !== 1'b1 || ack[2] !== 1'b0) begin bad++; $display("FAIL nonowner_ack: req2=%b ack2=%b required 1/0", req[2], ack[2]); end
    n = 0;
    while (gnt === 4'b0001 && n < 10) begin tick(); n++; end
    total++;
    if (gnt !== 4'b0 || beat_cnt !== 3'd4) begin bad++; $display("FAIL cap_release: gnt=%b cnt=%0d required 0000/4", gnt, beat_cnt); end
    tick();
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL cap_next_gnt: got %b required 0100", gnt); end
    wait_idle("cap", 30);
    total++;
    if (beat_cnt !== 3'd2) begin bad++; $display("FAIL cap_remainder: cnt=%0d required 2", beat_cnt); end
  endtask

  task automatic test_abandon();
    int n = 0;
    enq(3, 0, 3, 3);
    exp_q.push_back(mk(3, 0, 1));
    exp_gnt.push_back(4'd8);
    while (!(gnt === 4'b1000 && beat_cnt === 3'd1) && n < 10) begin tick(); n++; end
    drop_mask = 4'b1000;
    #1;
    total++;
    if (ack !== 4'b0) begin bad++; $display("FAIL abandon_ack: got %b required 0000", ack); end
    tick();
    total++;
    if (gnt !== 4'b0 || beat_cnt !== 3'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL abandon_release: gnt=%b cnt=%0d busy=%b required 0000/1/0", gnt, beat_cnt, busy);
    end
    enq(0, 2, 1, 1); enq(2, 2, 1, 1);
    exp_q.push_back(mk(0, 2, 1)); exp_q.push_back(mk(2, 2, 1));
    exp_gnt.push_back(4'd1); exp_gnt.push_back(4'd4);
    tick(); tick();
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL abandon_last_owner: gnt=%b required 0001", gnt); end
    wait_idle("abandon", 20);
  endtask

  task automatic test_async_reset();
    int n = 0;
    enq(1, 3, 4, 4);
    exp_gnt.push_back(4'd2);
    while (busy !== 1'b1 && n < 10) begin tick(); n++; end
    total++;
    if (gnt !== 4'b0010 || fifo_w_req !== 1'b1) begin bad++; $display("FAIL ar_pre: gnt=%b wr=%b required 0010/1", gnt, fifo_w_req); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 4'b0 || busy !== 1'b0 || fifo_w_req !== 1'b0 || ack !== 4'b0 || fifo_data !== 64'd0 || beat_cnt !== 3'd0) begin
      bad++; $display("FAIL ar_immediate: gnt=%b busy=%b wr=%b ack=%b data=%h cnt=%0d required all 0",
                      gnt, busy, fifo_w_req, ack, fifo_data, beat_cnt);
    end
    for (int i = 0; i < NREQ; i++) begin pq_data[i].delete(); pq_last[i].delete(); end
    exp_q.delete(); exp_gnt.delete();
    drop_mask = 4'b0;
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin enq(i, 4, 1, 1); exp_q.push_back(mk(i, 4, 1)); end
    exp_gnt.push_back(4'd1); exp_gnt.push_back(4'd2); exp_gnt.push_back(4'd4); exp_gnt.push_back(4'd8);
    n = 0;
    while (gnt === 4'b0 && n < 10) begin tick(); n++; end
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL ar_first_grant: got %b required 0001", gnt); end
    wait_idle("ar", 30);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; fifo_full = 1'b0; drop_mask = 4'b0; prev_gnt = 4'b0; acc = 4'b0;
    req_base = 4'b0; last = 4'b0; data_i = '0;
    test_reset();
    test_round_robin();
    test_basic();
    test_backpressure();
    test_max_beats();
    test_abandon();
    test_async_reset();
    total++;
    if (exp_q.size() != 0 || exp_gnt.size() != 0) begin
      bad++; $display("FAIL leftover: data=%0d grants=%0d required 0/0", exp_q.size(), exp_gnt.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
